panda_risc_v_dpc_tracker: RTL and testbench
===========================================

Name: panda_risc_v_dpc_tracker

Overview:
- In-flight instruction scoreboard that tracks every instruction from decode through dispatch to retire.
- Answers the decode/dispatch stage's RAW and WAW queries (rs1/rs2/rd against destination registers of dispatched, un-retired instructions).
- Exerts back-pressure when the tracking table is full.
- Sits beside the decode/dispatch unit and consumes its dpc_trace_dcd/dpc_trace_dsptc events plus retire events from write-back.

Parameters:
ENTRY_N, 4, number of tracking-table entries (2..8)
INST_ID_W, 4, instruction-ID width

Ports:
clk  in  1  clock
sys_reset  in  1  asynchronous active-high reset
flush_req  in  1  pipeline flush; kills undispatched entries
dpc_trace_dcd_inst_id  in  INST_ID_W  ID of instruction being decoded
dpc_trace_dcd_rd_id  in  5  its RD index
dpc_trace_dcd_rd_vld  in  1  it writes RD
dpc_trace_dcd_is_long  in  1  it is a long instruction (load/CSR/mul/div)
dpc_trace_dcd_valid  in  1  decode event
dpc_trace_dsptc_inst_id  in  INST_ID_W  ID of instruction being dispatched
dpc_trace_dsptc_valid  in  1  dispatch event
dpc_trace_retire_inst_id  in  INST_ID_W  ID of instruction retiring (RD written or discarded)
dpc_trace_retire_valid  in  1  retire event
raw_dpc_check_rs1_id  in  5  RS1 to check
rs1_raw_dpc  out  1  RS1 has RAW hazard
raw_dpc_check_rs2_id  in  5  RS2 to check
rs2_raw_dpc  out  1  RS2 has RAW hazard
waw_dpc_check_rd_id  in  5  RD to check
rd_waw_dpc  out  1  RD collides with an in-flight long instruction
dpc_trace_full  out  1  no FREE entry
dpc_trace_empty  out  1  all entries FREE
dpc_trace_inflight_n  out  $clog2(ENTRY_N+1)  number of non-FREE entries (registered)

Behaviour:
- Per-entry state: FREE / DCD (decoded, not dispatched) / DSPTC (dispatched, not retired).
- Per-entry fields: inst_id, rd_id, rd_vld, is_long.
- Reset (async, any time, including mid-operation):
  - all entries FREE.
  - inflight_n=0, full=0, empty=1.
  - rs1/rs2_raw_dpc and rd_waw_dpc = 0 (no valid entries).
- All state updates take effect at the next rising edge. Queries and full/empty are combinational from registered state. inflight_n is a register updated alongside the state.
- Allocate:
  - Condition: dcd_valid & ~full & ~flush_req.
  - The lowest-index entry FREE at the start of the cycle moves to DCD and captures the fields.
  - dcd_valid while full: event dropped, no state change. Upstream must gate on full.
- Dispatch: dsptc_valid moves the entry in DCD with matching inst_id to DSPTC. No match: ignored.
- Retire:
  - retire_valid moves the entry in DSPTC with matching inst_id to FREE.
  - Same-cycle dispatch and retire of the same ID: entry goes to FREE.
  - No match: ignored.
- Flush:
  - flush_req frees all DCD entries after that cycle's dispatch is applied. A same-cycle dispatched entry becomes DSPTC and survives.
  - DSPTC entries are untouched; they still retire normally.
- Entry freed this cycle is not allocatable until the next cycle (allocation uses start-of-cycle FREE vector).
- RAW query:
  - rsX_raw_dpc = OR over DSPTC entries of (rd_vld & rd_id==rsX_id & rsX_id!=0).
  - DCD entries are excluded, so an instruction never hazards against itself or younger ones.
- WAW query: rd_waw_dpc = OR over DSPTC entries of (is_long & rd_vld & rd_id==waw_rd_id & waw_rd_id!=0).
- inflight_n next = inflight_n + alloc − retired_cnt − flushed_cnt. Never wraps; bounded 0..ENTRY_N.
- Duplicate live inst_id is a protocol violation. It must raise a simulation-only assertion and has no defined behaviour.

Test Plan:
- Reset, then dcd id=3 rd=x5 rd_vld=1 -> next cycle inflight_n=1, empty=0; rs1_check=x5 gives rs1_raw_dpc=0 (still DCD).
- dsptc id=3 -> next cycle rs1_raw_dpc=1 and rs2_raw_dpc=1 for x5; rd_waw_dpc=0 (short). Retire id=3 -> hazards clear, inflight_n=0, empty=1.
- Allocate ids 0..3 (ENTRY_N=4) -> full=1. dcd id=4 -> dropped, inflight_n stays 4. Retire id=1 after dispatch -> full=0 next cycle; a dcd in the retire cycle is still dropped.
- Dispatch long id=2 rd=x0 -> rd_waw_dpc=0 and raw=0 for x0. Dispatch long id=5 rd=x7 -> rd_waw_dpc=1 for x7 until retire id=5.
- Two DCD entries (ids 6,7) plus one DSPTC entry (id 8): flush_req together with dsptc id=6 -> ids 6 and 8 remain, id 7 freed, inflight_n 3->2.
- Assert sys_reset mid-stream with 3 live entries -> immediately inflight_n=0, empty=1, all hazard outputs 0; normal allocation resumes after release.

Source files
------------

// File: rtl/panda_risc_v_dpc_tracker.sv
// In-flight instruction scoreboard for the decode/dispatch stage: tracks each
// instruction through DCD -> DSPTC -> FREE and answers RAW/WAW hazard queries.
module panda_risc_v_dpc_tracker #(
  parameter int ENTRY_N   = 4,
  parameter int INST_ID_W = 4
) (
  input  logic                           clk,
  input  logic                           sys_reset,
  input  logic                           flush_req,
  input  logic [INST_ID_W-1:0]           dpc_trace_dcd_inst_id,
  input  logic [4:0]                     dpc_trace_dcd_rd_id,
  input  logic                           dpc_trace_dcd_rd_vld,
  input  logic                           dpc_trace_dcd_is_long,
  input  logic                           dpc_trace_dcd_valid,
  input  logic [INST_ID_W-1:0]           dpc_trace_dsptc_inst_id,
  input  logic                           dpc_trace_dsptc_valid,
  input  logic [INST_ID_W-1:0]           dpc_trace_retire_inst_id,
  input  logic                           dpc_trace_retire_valid,
  input  logic [4:0]                     raw_dpc_check_rs1_id,
  output logic                           rs1_raw_dpc,
  input  logic [4:0]                     raw_dpc_check_rs2_id,
  output logic                           rs2_raw_dpc,
  input  logic [4:0]                     waw_dpc_check_rd_id,
  output logic                           rd_waw_dpc,
  output logic                           dpc_trace_full,
  output logic                           dpc_trace_empty,
  output logic [$clog2(ENTRY_N+1)-1:0]   dpc_trace_inflight_n
);

  localparam int CNT_W = $clog2(ENTRY_N + 1);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_DCD   = 2'd1,
    ST_DSPTC = 2'd2
  } entry_st_e;

  entry_st_e            r_state      [ENTRY_N];
  entry_st_e            w_state_next [ENTRY_N];
  logic [INST_ID_W-1:0] r_inst_id    [ENTRY_N];
  logic [4:0]           r_rd_id      [ENTRY_N];
  logic                 r_rd_vld     [ENTRY_N];
  logic                 r_is_long    [ENTRY_N];
  logic [CNT_W-1:0]     r_inflight_n;
  logic [CNT_W-1:0]     w_inflight_next;

  logic [ENTRY_N-1:0]   w_free;
  logic [ENTRY_N-1:0]   w_alloc_oh;
  logic                 w_alloc;

  always_comb begin
    for (int i = 0; i < ENTRY_N; i++) begin
      w_free[i] = (r_state[i] == ST_FREE);
    end
  end

  assign dpc_trace_full       = ~|w_free;
  assign dpc_trace_empty      = &w_free;
  assign dpc_trace_inflight_n = r_inflight_n;

  // Lowest set bit of the start-of-cycle FREE vector picks the allocation slot,
  // so an entry freed this cycle cannot be reused until the next one.
  assign w_alloc    = dpc_trace_dcd_valid & ~dpc_trace_full & ~flush_req;
  assign w_alloc_oh = w_alloc ? (w_free & ~(w_free - ENTRY_N'(1))) : '0;

  // Event ordering per entry: dispatch, then retire, then flush, then allocate.
  always_comb begin
    w_inflight_next = '0;
    for (int i = 0; i < ENTRY_N; i++) begin
      w_state_next[i] = r_state[i];
      if (r_state[i] == ST_DCD && dpc_trace_dsptc_valid &&
          r_inst_id[i] == dpc_trace_dsptc_inst_id) begin
        w_state_next[i] = ST_DSPTC;
      end
      if (w_state_next[i] == ST_DSPTC && dpc_trace_retire_valid &&
          r_inst_id[i] == dpc_trace_retire_inst_id) begin
        w_state_next[i] = ST_FREE;
      end
      if (w_state_next[i] == ST_DCD && flush_req) begin
        w_state_next[i] = ST_FREE;
      end
      if (w_alloc_oh[i]) begin
        w_state_next[i] = ST_DCD;
      end
      if (w_state_next[i] != ST_FREE) begin
        w_inflight_next = w_inflight_next + CNT_W'(1);
      end
    end
  end

  // Only dispatched entries are visible to hazard queries.
  always_comb begin
    rs1_raw_dpc = 1'b0;
    rs2_raw_dpc = 1'b0;
    rd_waw_dpc  = 1'b0;
    for (int i = 0; i < ENTRY_N; i++) begin
      if (r_state[i] == ST_DSPTC && r_rd_vld[i]) begin
        if (r_rd_id[i] == raw_dpc_check_rs1_id && raw_dpc_check_rs1_id != 5'd0) begin
          rs1_raw_dpc = 1'b1;
        end
        if (r_rd_id[i] == raw_dpc_check_rs2_id && raw_dpc_check_rs2_id != 5'd0) begin
          rs2_raw_dpc = 1'b1;
        end
        if (r_is_long[i] && r_rd_id[i] == waw_dpc_check_rd_id &&
            waw_dpc_check_rd_id != 5'd0) begin
          rd_waw_dpc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_inflight_n <= '0;
      for (int i = 0; i < ENTRY_N; i++) begin
        r_state[i]   <= ST_FREE;
        r_inst_id[i] <= '0;
        r_rd_id[i]   <= '0;
        r_rd_vld[i]  <= 1'b0;
        r_is_long[i] <= 1'b0;
      end
    end else begin
      r_inflight_n <= w_inflight_next;
      for (int i = 0; i < ENTRY_N; i++) begin
        r_state[i] <= w_state_next[i];
        if (w_alloc_oh[i]) begin
          r_inst_id[i] <= dpc_trace_dcd_inst_id;
          r_rd_id[i]   <= dpc_trace_dcd_rd_id;
          r_rd_vld[i]  <= dpc_trace_dcd_rd_vld;
          r_is_long[i] <= dpc_trace_dcd_is_long;
        end
      end
    end
  end

  // A newly decoded ID must not already be live in the table.
  always @(posedge clk) begin
    if (!sys_reset && w_alloc) begin
      for (int i = 0; i < ENTRY_N; i++) begin
        assert (w_free[i] || r_inst_id[i] != dpc_trace_dcd_inst_id)
          else $error("dpc_tracker: duplicate live inst_id %0d", dpc_trace_dcd_inst_id);
      end
    end
  end

endmodule

// File: tb/tb_panda_risc_v_dpc_tracker.sv
// Directed-vector bench for panda_risc_v_dpc_tracker (ENTRY_N=4, INST_ID_W=4).
module tb_panda_risc_v_dpc_tracker;

  logic       clk = 1'b0;
  logic       sys_reset;
  logic       flush_req;
  logic [3:0] dcd_inst_id;
  logic [4:0] dcd_rd_id;
  logic       dcd_rd_vld;
  logic       dcd_is_long;
  logic       dcd_valid;
  logic [3:0] dsptc_inst_id;
  logic       dsptc_valid;
  logic [3:0] retire_inst_id;
  logic       retire_valid;
  logic [4:0] rs1_id;
  logic       rs1_raw;
  logic [4:0] rs2_id;
  logic       rs2_raw;
  logic [4:0] waw_rd_id;
  logic       rd_waw;
  logic       full;
  logic       empty;
  logic [2:0] inflight_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  panda_risc_v_dpc_tracker #(.ENTRY_N(4), .INST_ID_W(4)) dut (
    .clk                      (clk),
    .sys_reset                (sys_reset),
    .flush_req                (flush_req),
    .dpc_trace_dcd_inst_id    (dcd_inst_id),
    .dpc_trace_dcd_rd_id      (dcd_rd_id),
    .dpc_trace_dcd_rd_vld     (dcd_rd_vld),
    .dpc_trace_dcd_is_long    (dcd_is_long),
    .dpc_trace_dcd_valid      (dcd_valid),
    .dpc_trace_dsptc_inst_id  (dsptc_inst_id),
    .dpc_trace_dsptc_valid    (dsptc_valid),
    .dpc_trace_retire_inst_id (retire_inst_id),
    .dpc_trace_retire_valid   (retire_valid),
    .raw_dpc_check_rs1_id     (rs1_id),
    .rs1_raw_dpc              (rs1_raw),
    .raw_dpc_check_rs2_id     (rs2_id),
    .rs2_raw_dpc              (rs2_raw),
    .waw_dpc_check_rd_id      (waw_rd_id),
    .rd_waw_dpc               (rd_waw),
    .dpc_trace_full           (full),
    .dpc_trace_empty          (empty),
    .dpc_trace_inflight_n     (inflight_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic idle();
    flush_req    = 1'b0;
    dcd_valid    = 1'b0;
    dsptc_valid  = 1'b0;
    retire_valid = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic dcd(input logic [3:0] id, input logic [4:0] rd, input logic lng);
    dcd_valid = 1'b1; dcd_inst_id = id; dcd_rd_id = rd; dcd_rd_vld = 1'b1; dcd_is_long = lng;
  endtask

  task automatic dsp(input logic [3:0] id);
    dsptc_valid = 1'b1; dsptc_inst_id = id;
  endtask

  task automatic ret(input logic [3:0] id);
    retire_valid = 1'b1; retire_inst_id = id;
  endtask

  task automatic query(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wd);
    rs1_id = r1; rs2_id = r2; waw_rd_id = wd;
    #1;
  endtask

  initial begin
    sys_reset = 1'b1;
    idle();
    dcd_inst_id = '0; dcd_rd_id = '0; dcd_rd_vld = 1'b0; dcd_is_long = 1'b0;
    dsptc_inst_id = '0; retire_inst_id = '0;
    rs1_id = '0; rs2_id = '0; waw_rd_id = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    sys_reset = 1'b0;
    query(5'd5, 5'd5, 5'd5);
    check("rst_inflight", inflight_n, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_rs1", rs1_raw, 0);

    // Decoded but not dispatched: no hazard yet
    dcd(4'd3, 5'd5, 1'b0); tick();
    query(5'd5, 5'd5, 5'd5);
    check("dcd_inflight", inflight_n, 1);
    check("dcd_empty", empty, 0);
    check("dcd_rs1_raw", rs1_raw, 0);

    dsp(4'd3); tick();
    query(5'd5, 5'd5, 5'd5);
    check("dsp_rs1_raw", rs1_raw, 1);
    check("dsp_rs2_raw", rs2_raw, 1);
    check("dsp_waw_short", rd_waw, 0);
    query(5'd6, 5'd0, 5'd5);
    check("dsp_rs1_other", rs1_raw, 0);

    ret(4'd3); tick();
    query(5'd5, 5'd5, 5'd5);
    check("ret_rs1_raw", rs1_raw, 0);
    check("ret_inflight", inflight_n, 0);
    check("ret_empty", empty, 1);

    // Fill the table
    for (int i = 0; i < 4; i++) begin
      dcd(4'(i), 5'(10 + i), 1'b0); tick();
    end
    check("fill_full", full, 1);
    check("fill_inflight", inflight_n, 4);
    dcd(4'd4, 5'd20, 1'b0); tick();
    check("drop_inflight", inflight_n, 4);
    check("drop_full", full, 1);
    dsp(4'd1); tick();
    ret(4'd1); dcd(4'd9, 5'd21, 1'b0); tick();
    check("ret_unfull", full, 0);
    check("ret_drop_inflight", inflight_n, 3);

    // Flush alone frees all DCD entries
    flush_req = 1'b1; tick();
    check("flush_inflight", inflight_n, 0);
    check("flush_empty", empty, 1);

    // Long instructions and x0
    dcd(4'd2, 5'd0, 1'b1); tick();
    dsp(4'd2); tick();
    query(5'd0, 5'd0, 5'd0);
    check("x0_waw", rd_waw, 0);
    check("x0_raw", rs1_raw, 0);
    dcd(4'd5, 5'd7, 1'b1); tick();
    query(5'd0, 5'd0, 5'd7);
    check("long_waw_dcd", rd_waw, 0);
    dsp(4'd5); tick();
    query(5'd7, 5'd0, 5'd7);
    check("long_waw", rd_waw, 1);
    check("long_raw", rs1_raw, 1);
    query(5'd7, 5'd0, 5'd8);
    check("long_waw_other", rd_waw, 0);
    ret(4'd5); tick();
    query(5'd7, 5'd0, 5'd7);
    check("long_waw_ret", rd_waw, 0);
    ret(4'd2); tick();
    check("long_empty", empty, 1);

    // Flush with same-cycle dispatch
    dcd(4'd6, 5'd1, 1'b0); tick();
    dcd(4'd7, 5'd2, 1'b0); tick();
    dcd(4'd8, 5'd3, 1'b0); tick();
    dsp(4'd8); tick();
    check("pre_flush_inflight", inflight_n, 3);
    flush_req = 1'b1; dsp(4'd6); tick();
    check("post_flush_inflight", inflight_n, 2);
    query(5'd1, 5'd3, 5'd0);
    check("flush_id6_kept", rs1_raw, 1);
    check("flush_id8_kept", rs2_raw, 1);
    dsp(4'd7); tick();
    query(5'd2, 5'd0, 5'd0);
    check("flush_id7_gone", rs1_raw, 0);
    check("nomatch_inflight", inflight_n, 2);

    // Same-cycle dispatch and retire
    dcd(4'd9, 5'd4, 1'b0); tick();
    check("dr_alloc_inflight", inflight_n, 3);
    dsp(4'd9); ret(4'd9); tick();
    query(5'd4, 5'd0, 5'd0);
    check("dr_inflight", inflight_n, 2);
    check("dr_rs1_raw", rs1_raw, 0);

    // Asynchronous reset mid-stream
    dcd(4'd10, 5'd5, 1'b1); tick();
    check("pre_rst_inflight", inflight_n, 3);
    #2 sys_reset = 1'b1;
    query(5'd1, 5'd3, 5'd3);
    check("arst_inflight", inflight_n, 0);
    check("arst_empty", empty, 1);
    check("arst_rs1", rs1_raw, 0);
    check("arst_rs2", rs2_raw, 0);
    @(posedge clk); #1;
    sys_reset = 1'b0;
    dcd(4'd11, 5'd6, 1'b0); tick();
    check("resume_inflight", inflight_n, 1);
    dsp(4'd11); tick();
    query(5'd6, 5'd0, 5'd0);
    check("resume_raw", rs1_raw, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
